// File: rtl/gpu_cmd_queue_pkg.sv
// Shared types for the GPU command queue: opcodes, FSM states, command record, width helpers.
package gpu_cmd_queue_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_DRAW  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_FENCE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FENCE  = 3'd4
  } state_e;

  // Framebuffer-independent head of a queued command; the top appends the
  // geometry fields (width, x, height, y) whose widths follow the framebuffer.
  typedef struct packed {
    op_e         op;
    logic [31:0] address;
    logic [15:0] address_x;
    logic [15:0] address_y;
    logic [15:0] image_width;
    logic [15:0] clear_color;
  } cmd_fixed_t;

  function automatic int coord_bits(input int extent);
    return $clog2(extent) + 2;
  endfunction

  function automatic int level_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gpu_cmd_queue_if.sv
// CPU-side push bus of the GPU command queue; master = CPU/MMIO, slave = queue.
interface gpu_cmd_queue_if #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
) ();
  localparam int W = gpu_cmd_queue_pkg::coord_bits(FB_WIDTH);
  localparam int H = gpu_cmd_queue_pkg::coord_bits(FB_HEIGHT);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [31:0]  cmd_address;
  logic [15:0]  cmd_address_x;
  logic [15:0]  cmd_address_y;
  logic [15:0]  cmd_image_width;
  logic [W-1:0] cmd_width;
  logic [W-1:0] cmd_x;
  logic [H-1:0] cmd_height;
  logic [H-1:0] cmd_y;
  logic [15:0]  cmd_clear_color;

  modport master (
    output cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
           cmd_image_width, cmd_width, cmd_x, cmd_height, cmd_y, cmd_clear_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
           cmd_image_width, cmd_width, cmd_x, cmd_height, cmd_y, cmd_clear_color,
    output cmd_ready
  );
endinterface

// File: rtl/gpu_cmd_queue_fifo.sv
// Generic synchronous FIFO, DEPTH a power of two; head word shown combinationally.
// Latency: a push is visible at the head from the next cycle.
// Backpressure: full is registered state, a pop frees its slot only from the next cycle.
module gpu_cmd_queue_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/gpu_cmd_queue.sv
// Queues CPU draw/clear commands and replays each onto the GPU ctrl pins as a one-cycle strobe.
// Latency: push at edge t into an idle queue -> ctrl fields after t+1, strobe high t+2..t+3.
// Backpressure: cmd_ready = !full; commands issue only while gpu_busy is low. GPU_CMD_VSYNC_EN adds vsync-gated FENCE.
module gpu_cmd_queue
  import gpu_cmd_queue_pkg::*;
#(
  parameter  int FB_WIDTH    = 400,
  parameter  int FB_HEIGHT   = 240,
  parameter  int QUEUE_DEPTH = 8,
  localparam int W  = coord_bits(FB_WIDTH),
  localparam int H  = coord_bits(FB_HEIGHT),
  localparam int LW = level_bits(QUEUE_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  gpu_cmd_queue_if.slave   cmd,
  output logic [31:0]      ctrl_address,
  output logic [15:0]      ctrl_address_x,
  output logic [15:0]      ctrl_address_y,
  output logic [15:0]      ctrl_image_width,
  output logic [W-1:0]     ctrl_width,
  output logic [W-1:0]     ctrl_x,
  output logic [H-1:0]     ctrl_height,
  output logic [H-1:0]     ctrl_y,
  output logic [15:0]      ctrl_clear_color,
  output logic             ctrl_draw,
  output logic             ctrl_clear,
`ifdef GPU_CMD_VSYNC_EN
  input  logic             vsync,
`endif
  input  logic             gpu_busy,
  output logic [LW-1:0]    queue_level,
  output logic [15:0]      done_count,
  output logic             idle
);
  typedef struct packed {
    cmd_fixed_t   f;
    logic [W-1:0] width;
    logic [W-1:0] x;
    logic [H-1:0] height;
    logic [H-1:0] y;
  } cmd_t;

  localparam int CW = $bits(cmd_t);

  cmd_t   push_word;
  cmd_t   head;
  cmd_t   cur;
  state_e state;
  state_e nxt;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   retire;

  always_comb begin
    push_word               = '0;
    push_word.f.op          = op_e'(cmd.cmd_op);
    push_word.f.address     = cmd.cmd_address;
    push_word.f.address_x   = cmd.cmd_address_x;
    push_word.f.address_y   = cmd.cmd_address_y;
    push_word.f.image_width = cmd.cmd_image_width;
    push_word.f.clear_color = cmd.cmd_clear_color;
    push_word.width         = cmd.cmd_width;
    push_word.x             = cmd.cmd_x;
    push_word.height        = cmd.cmd_height;
    push_word.y             = cmd.cmd_y;
  end

  gpu_cmd_queue_fifo #(
    .WIDTH (CW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd.cmd_valid),
    .push_dat (push_word),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (queue_level)
  );

  assign cmd.cmd_ready = !fifo_full;
  assign idle          = fifo_empty && (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    pop    = 1'b0;
    retire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          nxt = ST_SETUP;
        end
      end
      // Fields were loaded on entry, so the GPU sees them for a full cycle before any strobe.
      ST_SETUP: begin
        case (cur.f.op)
          OP_NOP: begin
            retire = 1'b1;
            nxt    = ST_IDLE;
          end
          OP_FENCE: begin
`ifdef GPU_CMD_VSYNC_EN
            nxt    = ST_FENCE;
`else
            retire = 1'b1;
            nxt    = ST_IDLE;
`endif
          end
          default: begin
            if (!gpu_busy) nxt = ST_STROBE;
          end
        endcase
      end
      ST_STROBE: nxt = ST_WAIT;
      ST_WAIT: begin
        if (!gpu_busy) begin
          retire = 1'b1;
          nxt    = ST_IDLE;
        end
      end
      ST_FENCE: begin
`ifdef GPU_CMD_VSYNC_EN
        if (vsync && !gpu_busy) begin
          retire = 1'b1;
          nxt    = ST_IDLE;
        end
`else
        retire = 1'b1;
        nxt    = ST_IDLE;
`endif
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= '0;
      ctrl_draw  <= 1'b0;
      ctrl_clear <= 1'b0;
      done_count <= '0;
    end else begin
      if (pop)    cur        <= head;
      if (retire) done_count <= done_count + 16'd1;
      ctrl_draw  <= (nxt == ST_STROBE) && (cur.f.op == OP_DRAW);
      ctrl_clear <= (nxt == ST_STROBE) && (cur.f.op == OP_CLEAR);
    end
  end

  assign ctrl_address     = cur.f.address;
  assign ctrl_address_x   = cur.f.address_x;
  assign ctrl_address_y   = cur.f.address_y;
  assign ctrl_image_width = cur.f.image_width;
  assign ctrl_clear_color = cur.f.clear_color;
  assign ctrl_width       = cur.width;
  assign ctrl_x           = cur.x;
  assign ctrl_height      = cur.height;
  assign ctrl_y           = cur.y;
endmodule
